// File: rtl/TauCfg.sv
// Shared TileAccumUnit configuration: work width, dimensionality and the
// packed per-dimension offset vector used along the block-offset path.
package TauCfg;

    localparam int unsigned WORK_BW = 16;
    localparam int unsigned DIM     = 2;

    // Element [d] holds dimension d; dimension DIM-1 is the innermost.
    typedef logic [DIM-1:0][WORK_BW-1:0] bofs_vec_t;

endpackage

// File: rtl/bofs_iterator_pkg.sv
// Helpers local to the block-offset iterator.
package bofs_iterator_pkg;

    import TauCfg::*;

    // A range is empty when any dimension has begin at or past its end.
    function automatic logic any_empty(input bofs_vec_t beg, input bofs_vec_t bnd);
        logic r;
        r = 1'b0;
        for (int d = 0; d < int'(DIM); d++) begin
            if (beg[d] >= bnd[d]) r = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bofs_odometer_step.sv
// One combinational odometer step over a DIM-wide offset.
// Ports:
//   cur_i, beg_i, end_i, stride_i : current offset and range configuration
//   next_o                        : offset after one advance
//   all_wrap_o                    : every dimension wraps, i.e. cur_i is the final offset
module bofs_odometer_step
    import TauCfg::*;
(
    input  logic [DIM-1:0][WORK_BW-1:0] cur_i,
    input  logic [DIM-1:0][WORK_BW-1:0] beg_i,
    input  logic [DIM-1:0][WORK_BW-1:0] end_i,
    input  logic [DIM-1:0][WORK_BW-1:0] stride_i,
    output logic [DIM-1:0][WORK_BW-1:0] next_o,
    output logic                        all_wrap_o
);

    localparam int unsigned SUM_BW = WORK_BW + 1;

    // Carry ripples from the innermost dimension outward; the sum keeps an
    // extra bit so offsets near the top of the range never alias to zero.
    always_comb begin
        logic              carry;
        logic [SUM_BW-1:0] sum;
        next_o = cur_i;
        carry  = 1'b1;
        sum    = '0;
        for (int d = int'(DIM) - 1; d >= 0; d--) begin
            sum = SUM_BW'(cur_i[d]) + SUM_BW'(stride_i[d]);
            if (carry) begin
                if ((stride_i[d] == '0) || (sum >= SUM_BW'(end_i[d]))) begin
                    next_o[d] = beg_i[d];
                end else begin
                    next_o[d] = sum[WORK_BW-1:0];
                    carry     = 1'b0;
                end
            end
        end
        all_wrap_o = carry;
    end

endmodule

// File: rtl/bofs_iterator.sv
// Block-offset sequencer: accepts one begin/end/stride range per tile and
// walks it as a nested odometer (innermost dimension DIM-1), one offset per
// handshake, alongside the registered range boundary.
// Ports:
//   i_clk, i_rst                    : clock, async active-low reset
//   i_cfg_valid / o_cfg_ready       : configuration handshake
//   i_bofs_beg/end/stride           : per-dimension range configuration
//   o_valid / i_ready               : offset output handshake
//   o_bofs, o_bboundary, o_last     : current offset, range end, final-offset flag
module bofs_iterator
    import TauCfg::*;
    import bofs_iterator_pkg::*;
(
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_cfg_valid,
    output logic                        o_cfg_ready,
    input  logic [DIM-1:0][WORK_BW-1:0] i_bofs_beg,
    input  logic [DIM-1:0][WORK_BW-1:0] i_bofs_end,
    input  logic [DIM-1:0][WORK_BW-1:0] i_bofs_stride,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic [DIM-1:0][WORK_BW-1:0] o_bofs,
    output logic [DIM-1:0][WORK_BW-1:0] o_bboundary,
    output logic                        o_last
);

    typedef enum logic {IDLE, RUN} state_e;

    state_e    state_q, state_d;
    logic      valid_q, valid_d;
    logic      cfg_ready_q, cfg_ready_d;
    logic      last_q, last_d;
    bofs_vec_t bofs_q, bofs_d;
    bofs_vec_t beg_q, beg_d;
    bofs_vec_t bnd_q, bnd_d;
    bofs_vec_t stride_q, stride_d;

    bofs_vec_t step_next;
    logic      step_wrap;
    bofs_vec_t look_cur, look_beg, look_end, look_stride;
    bofs_vec_t look_next;
    logic      look_wrap;

    // Advance of the live offset.
    bofs_odometer_step u_step (
        .cur_i      (bofs_q),
        .beg_i      (beg_q),
        .end_i      (bnd_q),
        .stride_i   (stride_q),
        .next_o     (step_next),
        .all_wrap_o (step_wrap)
    );

    // Look-ahead on whatever offset gets loaded next: the incoming begin
    // vector while idle, the advanced offset while running. Its wrap flag
    // becomes the registered o_last.
    always_comb begin
        if (state_q == IDLE) begin
            look_cur    = i_bofs_beg;
            look_beg    = i_bofs_beg;
            look_end    = i_bofs_end;
            look_stride = i_bofs_stride;
        end else begin
            look_cur    = step_next;
            look_beg    = beg_q;
            look_end    = bnd_q;
            look_stride = stride_q;
        end
    end

    bofs_odometer_step u_look (
        .cur_i      (look_cur),
        .beg_i      (look_beg),
        .end_i      (look_end),
        .stride_i   (look_stride),
        .next_o     (look_next),
        .all_wrap_o (look_wrap)
    );

    // State and datapath registers.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= IDLE;
            valid_q     <= 1'b0;
            cfg_ready_q <= 1'b1;
            last_q      <= 1'b0;
            bofs_q      <= '0;
            beg_q       <= '0;
            bnd_q       <= '0;
            stride_q    <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            cfg_ready_q <= cfg_ready_d;
            last_q      <= last_d;
            bofs_q      <= bofs_d;
            beg_q       <= beg_d;
            bnd_q       <= bnd_d;
            stride_q    <= stride_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        bofs_d   = bofs_q;
        beg_d    = beg_q;
        bnd_d    = bnd_q;
        stride_d = stride_q;

        case (state_q)
            IDLE: begin
                if (i_cfg_valid && cfg_ready_q) begin
                    beg_d    = i_bofs_beg;
                    bnd_d    = i_bofs_end;
                    stride_d = i_bofs_stride;
                    // Empty ranges are latched but produce no output.
                    if (!any_empty(i_bofs_beg, i_bofs_end)) begin
                        bofs_d  = i_bofs_beg;
                        last_d  = look_wrap;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (valid_q && i_ready) begin
                    // step_wrap on the live offset is the same condition as o_last.
                    if (step_wrap) begin
                        last_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        bofs_d = step_next;
                        last_d = look_wrap;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        valid_d     = (state_d == RUN);
        cfg_ready_d = (state_d == IDLE);
    end

    assign o_valid     = valid_q;
    assign o_cfg_ready = cfg_ready_q;
    assign o_last      = last_q;
    assign o_bofs      = bofs_q;
    assign o_bboundary = bnd_q;

endmodule

// File: tb/tb_bofs_iterator.sv
module tb_bofs_iterator;

    import TauCfg::*;

    logic      clk = 1'b0;
    logic      rst_n;
    logic      cfg_valid;
    logic      cfg_ready;
    bofs_vec_t beg, bnd, stride;
    logic      valid;
    logic      ready;
    bofs_vec_t bofs;
    bofs_vec_t bboundary;
    logic      last;

    int n_vec = 0;
    int n_err = 0;

    bofs_vec_t exp_q[$];

    always #5 clk = ~clk;

    bofs_iterator dut (
        .i_clk         (clk),
        .i_rst         (rst_n),
        .i_cfg_valid   (cfg_valid),
        .o_cfg_ready   (cfg_ready),
        .i_bofs_beg    (beg),
        .i_bofs_end    (bnd),
        .i_bofs_stride (stride),
        .o_valid       (valid),
        .i_ready       (ready),
        .o_bofs        (bofs),
        .o_bboundary   (bboundary),
        .o_last        (last)
    );

    function automatic bofs_vec_t mk(input int unsigned d0, input int unsigned d1);
        bofs_vec_t v;
        v[0] = WORK_BW'(d0);
        v[1] = WORK_BW'(d1);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Applies one configuration and follows the output stream against exp_q.
    task automatic run_cfg(input bofs_vec_t b, input bofs_vec_t e, input bofs_vec_t s,
                           input bit rnd, input string tag);
        int  idx;
        int  cyc;
        int  n;
        bit  rdy;
        n = exp_q.size();
        @(negedge clk);
        chk({tag, "_cfg_ready_idle"}, 64'(cfg_ready), 64'(1));
        cfg_valid = 1'b1;
        beg = b; bnd = e; stride = s;
        @(negedge clk);
        cfg_valid = 1'b0;
        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 400) begin
            chk({tag, "_valid"}, 64'(valid), 64'(1));
            if (valid !== 1'b1) begin
                cyc = 400;
            end else begin
                chk({tag, "_bofs"}, 64'(bofs), 64'(exp_q[idx]));
                chk({tag, "_last"}, 64'(last), 64'(idx == n - 1));
                chk({tag, "_bboundary"}, 64'(bboundary), 64'(e));
                chk({tag, "_cfg_ready_run"}, 64'(cfg_ready), 64'(0));
                rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                ready = rdy;
                if (rdy) idx++;
                @(negedge clk);
                cyc++;
            end
        end
        chk({tag, "_count"}, 64'(idx), 64'(n));
        chk({tag, "_valid_after"}, 64'(valid), 64'(0));
        chk({tag, "_cfg_ready_after"}, 64'(cfg_ready), 64'(1));
        ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        ready     = 1'b0;
        beg       = '0;
        bnd       = '0;
        stride    = '0;
        #12;
        chk("rst_valid", 64'(valid), 64'(0));
        chk("rst_last", 64'(last), 64'(0));
        chk("rst_cfg_ready", 64'(cfg_ready), 64'(1));
        chk("rst_bofs", 64'(bofs), 64'(0));
        chk("rst_bboundary", 64'(bboundary), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Basic order.
        exp_q = '{mk(0,0), mk(0,1), mk(0,2), mk(1,0), mk(1,1), mk(1,2)};
        run_cfg(mk(0,0), mk(2,3), mk(1,1), 1'b0, "basic");

        // Strided range.
        exp_q = '{mk(0,0), mk(0,4), mk(2,0), mk(2,4)};
        run_cfg(mk(0,0), mk(4,8), mk(2,4), 1'b0, "stride");

        // Backpressure: same sequence as basic under random ready.
        exp_q = '{mk(0,0), mk(0,1), mk(0,2), mk(1,0), mk(1,1), mk(1,2)};
        run_cfg(mk(0,0), mk(2,3), mk(1,1), 1'b1, "bp");

        // Empty range: nothing emitted, stays ready.
        @(negedge clk);
        cfg_valid = 1'b1;
        beg = mk(3,0); bnd = mk(3,5); stride = mk(1,1);
        @(negedge clk);
        cfg_valid = 1'b0;
        ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("empty_valid", 64'(valid), 64'(0));
            chk("empty_cfg_ready", 64'(cfg_ready), 64'(1));
            @(negedge clk);
        end
        ready = 1'b0;

        // Zero stride in the outer dimension.
        exp_q = '{mk(0,0), mk(0,1)};
        run_cfg(mk(0,0), mk(4,2), mk(0,1), 1'b0, "zstride");

        // Overflow edge: 0xFFFC + 4 must wrap the dimension, not alias to 0.
        exp_q = '{mk(0,16'hFFFC)};
        run_cfg(mk(0,16'hFFFC), mk(1,16'hFFFF), mk(1,4), 1'b0, "ovf");

        // Reset after the second handshake.
        @(negedge clk);
        cfg_valid = 1'b1;
        beg = mk(0,0); bnd = mk(2,3); stride = mk(1,1);
        @(negedge clk);
        cfg_valid = 1'b0;
        ready = 1'b1;
        chk("rstrun_bofs0", 64'(bofs), 64'(mk(0,0)));
        @(negedge clk);
        chk("rstrun_bofs1", 64'(bofs), 64'(mk(0,1)));
        @(negedge clk);
        chk("rstrun_bofs2", 64'(bofs), 64'(mk(0,2)));
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstrun_valid", 64'(valid), 64'(0));
        chk("rstrun_cfg_ready", 64'(cfg_ready), 64'(1));
        chk("rstrun_bofs", 64'(bofs), 64'(0));
        ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Fresh configuration restarts from its own begin.
        exp_q = '{mk(1,1), mk(1,2)};
        run_cfg(mk(1,1), mk(2,3), mk(1,1), 1'b0, "restart");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
